// File: rtl/sdp_y_alu_pkg.sv
// ---------------------------------------------------------------------------
// sdp_y_alu_pkg
// Shared constants, payload type and width helpers for the SDP Y ALU
// channel bridge and its FIFOs.
// ---------------------------------------------------------------------------
package sdp_y_alu_pkg;

  localparam int SDP_Y_ALU_DW           = 128;
  localparam int SDP_Y_ALU_BRIDGE_DEPTH = 2;

  // Channel slots inside the bridge's FIFO array
  localparam int SDP_Y_ALU_CH_IN  = 0;
  localparam int SDP_Y_ALU_CH_OP  = 1;
  localparam int SDP_Y_ALU_CH_OUT = 2;
  localparam int SDP_Y_ALU_NUM_CH = 3;

  typedef logic [SDP_Y_ALU_DW-1:0] sdp_y_alu_word_t;

  // Count must hold 0..DEPTH inclusive, hence one bit above the pointer.
  function automatic int sdp_y_alu_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int sdp_y_alu_cnt_w(input int depth);
    return sdp_y_alu_ptr_w(depth) + 1;
  endfunction

  // Saturating 32-bit increment for the optional performance counters
  function automatic logic [31:0] sdp_y_alu_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sdp_y_alu_chn_fifo.sv
// ---------------------------------------------------------------------------
// sdp_y_alu_chn_fifo
// DEPTH x DW synchronous FIFO, no bypass (write visible on o_head the cycle
// after the push). DEPTH must be a power of two so pointers wrap naturally.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (clears storage too, so the
//                head reads 0 out of reset)
//   i_push       write request; ignored while full
//   i_wdata      write payload
//   i_pop        read request; ignored while empty
//   o_head       entry at the read pointer
//   o_count      occupancy 0..DEPTH
//   o_full       count == DEPTH
//   o_empty      count == 0
// ---------------------------------------------------------------------------
module sdp_y_alu_chn_fifo
  import sdp_y_alu_pkg::*;
#(
  parameter  int DW    = SDP_Y_ALU_DW,
  parameter  int DEPTH = SDP_Y_ALU_BRIDGE_DEPTH,
  localparam int AW    = sdp_y_alu_ptr_w(DEPTH),
  localparam int CW    = sdp_y_alu_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // Guard internally as well so a stray request can never corrupt state
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdp_y_alu_chn_bridge.sv
// ---------------------------------------------------------------------------
// sdp_y_alu_chn_bridge
// Channel-side partner of the SDP Y ALU core. Converts upstream pvld/prdy
// streams into the core's wait-handshake inputs (chn_alu_in, chn_alu_op)
// and drains the core's output channel into a downstream pvld/prdy stream.
// Each channel has its own DEPTH-entry FIFO; no cross-channel pairing.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   up_in_*  / up_op_*                 upstream pvld/prdy/pd streams
//   chn_alu_in_rsc_* / chn_alu_op_rsc_* z=FIFO head, vz=non-empty, lz=consume
//   chn_alu_out_rsc_*                  z=core result, vz=space, lz=result valid
//   dn_out_*                           downstream pvld/prdy/pd stream
//   bridge_idle                        registered "all FIFOs empty"
//
// Optional: define SDP_Y_ALU_BRIDGE_PERF_EN to add saturating 32-bit
// counters perf_in_cnt, perf_op_cnt, perf_out_cnt (core-side transfers)
// and perf_stall_cnt (cycles where the core offers a result with no space).
// ---------------------------------------------------------------------------
module sdp_y_alu_chn_bridge
  import sdp_y_alu_pkg::*;
#(
  parameter int DW    = SDP_Y_ALU_DW,
  parameter int DEPTH = SDP_Y_ALU_BRIDGE_DEPTH
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          up_in_pvld,
  output logic          up_in_prdy,
  input  logic [DW-1:0] up_in_pd,
  input  logic          up_op_pvld,
  output logic          up_op_prdy,
  input  logic [DW-1:0] up_op_pd,
  output logic [DW-1:0] chn_alu_in_rsc_z,
  output logic          chn_alu_in_rsc_vz,
  input  logic          chn_alu_in_rsc_lz,
  output logic [DW-1:0] chn_alu_op_rsc_z,
  output logic          chn_alu_op_rsc_vz,
  input  logic          chn_alu_op_rsc_lz,
  input  logic [DW-1:0] chn_alu_out_rsc_z,
  output logic          chn_alu_out_rsc_vz,
  input  logic          chn_alu_out_rsc_lz,
  output logic          dn_out_pvld,
  input  logic          dn_out_prdy,
  output logic [DW-1:0] dn_out_pd,
  output logic          bridge_idle
`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
  ,
  output logic [31:0]   perf_in_cnt,
  output logic [31:0]   perf_op_cnt,
  output logic [31:0]   perf_out_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int NCH = SDP_Y_ALU_NUM_CH;
  localparam int CW  = sdp_y_alu_cnt_w(DEPTH);

  logic [NCH-1:0]         w_push;
  logic [NCH-1:0]         w_pop;
  logic [NCH-1:0][DW-1:0] w_wdata;
  logic [NCH-1:0][DW-1:0] w_head;
  logic [NCH-1:0][CW-1:0] w_count;
  logic [NCH-1:0]         w_full;
  logic [NCH-1:0]         w_empty;
  logic                   r_idle;

  // Ready/space come straight from registered FIFO state, so there is no
  // combinational path from any lz pulse back to prdy/vz.
  assign up_in_prdy         = !w_full[SDP_Y_ALU_CH_IN];
  assign up_op_prdy         = !w_full[SDP_Y_ALU_CH_OP];
  assign chn_alu_out_rsc_vz = !w_full[SDP_Y_ALU_CH_OUT];

  assign chn_alu_in_rsc_vz  = !w_empty[SDP_Y_ALU_CH_IN];
  assign chn_alu_op_rsc_vz  = !w_empty[SDP_Y_ALU_CH_OP];
  assign dn_out_pvld        = !w_empty[SDP_Y_ALU_CH_OUT];

  assign chn_alu_in_rsc_z   = w_head[SDP_Y_ALU_CH_IN];
  assign chn_alu_op_rsc_z   = w_head[SDP_Y_ALU_CH_OP];
  assign dn_out_pd          = w_head[SDP_Y_ALU_CH_OUT];

  // Push/pop qualification; lz while empty (or full, on the out side) is a no-op
  assign w_push[SDP_Y_ALU_CH_IN]  = up_in_pvld && !w_full[SDP_Y_ALU_CH_IN];
  assign w_pop[SDP_Y_ALU_CH_IN]   = chn_alu_in_rsc_lz && !w_empty[SDP_Y_ALU_CH_IN];
  assign w_wdata[SDP_Y_ALU_CH_IN] = up_in_pd;

  assign w_push[SDP_Y_ALU_CH_OP]  = up_op_pvld && !w_full[SDP_Y_ALU_CH_OP];
  assign w_pop[SDP_Y_ALU_CH_OP]   = chn_alu_op_rsc_lz && !w_empty[SDP_Y_ALU_CH_OP];
  assign w_wdata[SDP_Y_ALU_CH_OP] = up_op_pd;

  assign w_push[SDP_Y_ALU_CH_OUT]  = chn_alu_out_rsc_lz && !w_full[SDP_Y_ALU_CH_OUT];
  assign w_pop[SDP_Y_ALU_CH_OUT]   = dn_out_prdy && !w_empty[SDP_Y_ALU_CH_OUT];
  assign w_wdata[SDP_Y_ALU_CH_OUT] = chn_alu_out_rsc_z;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sdp_y_alu_chn_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (nvdla_core_clk),
      .rst_n   (nvdla_core_rstn),
      .i_push  (w_push[g]),
      .i_wdata (w_wdata[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Idle lags the counts by one cycle
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_idle <= 1'b1;
    else                  r_idle <= (w_count == '0);
  end

  assign bridge_idle = r_idle;

`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
  logic [31:0] r_perf_in;
  logic [31:0] r_perf_op;
  logic [31:0] r_perf_out;
  logic [31:0] r_perf_stall;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_perf_in    <= '0;
      r_perf_op    <= '0;
      r_perf_out   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop[SDP_Y_ALU_CH_IN])   r_perf_in  <= sdp_y_alu_sat_inc(r_perf_in);
      if (w_pop[SDP_Y_ALU_CH_OP])   r_perf_op  <= sdp_y_alu_sat_inc(r_perf_op);
      if (w_push[SDP_Y_ALU_CH_OUT]) r_perf_out <= sdp_y_alu_sat_inc(r_perf_out);
      if (chn_alu_out_rsc_lz && w_full[SDP_Y_ALU_CH_OUT])
        r_perf_stall <= sdp_y_alu_sat_inc(r_perf_stall);
    end
  end

  assign perf_in_cnt    = r_perf_in;
  assign perf_op_cnt    = r_perf_op;
  assign perf_out_cnt   = r_perf_out;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_sdp_y_alu_chn_bridge.sv
// Directed bench for sdp_y_alu_chn_bridge (DW=128, DEPTH=2).
module tb_sdp_y_alu_chn_bridge;

  logic         clk;
  logic         rstn;
  logic         up_in_pvld, up_in_prdy;
  logic [127:0] up_in_pd;
  logic         up_op_pvld, up_op_prdy;
  logic [127:0] up_op_pd;
  logic [127:0] in_z, op_z, out_z, dn_pd;
  logic         in_vz, in_lz, op_vz, op_lz, out_vz, out_lz;
  logic         dn_pvld, dn_prdy, idle;
`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
  logic [31:0]  perf_in, perf_op, perf_out, perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  sdp_y_alu_chn_bridge #(.DW(128), .DEPTH(2)) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .up_in_pvld         (up_in_pvld),
    .up_in_prdy         (up_in_prdy),
    .up_in_pd           (up_in_pd),
    .up_op_pvld         (up_op_pvld),
    .up_op_prdy         (up_op_prdy),
    .up_op_pd           (up_op_pd),
    .chn_alu_in_rsc_z   (in_z),
    .chn_alu_in_rsc_vz  (in_vz),
    .chn_alu_in_rsc_lz  (in_lz),
    .chn_alu_op_rsc_z   (op_z),
    .chn_alu_op_rsc_vz  (op_vz),
    .chn_alu_op_rsc_lz  (op_lz),
    .chn_alu_out_rsc_z  (out_z),
    .chn_alu_out_rsc_vz (out_vz),
    .chn_alu_out_rsc_lz (out_lz),
    .dn_out_pvld        (dn_pvld),
    .dn_out_prdy        (dn_prdy),
    .dn_out_pd          (dn_pd),
    .bridge_idle        (idle)
`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
    ,
    .perf_in_cnt        (perf_in),
    .perf_op_cnt        (perf_op),
    .perf_out_cnt       (perf_out),
    .perf_stall_cnt     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after return take effect at the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] WA = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [127:0] WB = 128'hB0B0_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [127:0] WC = 128'hC0C0_0000_0000_0000_0000_0000_0000_00C3;

  initial begin
    rstn = 1'b0;
    up_in_pvld = 0; up_in_pd = '0; up_op_pvld = 0; up_op_pd = '0;
    in_lz = 0; op_lz = 0; out_lz = 0; out_z = '0; dn_prdy = 0;
    step(); step();

    // Reset state
    chk("rst_in_prdy", up_in_prdy, 1);
    chk("rst_op_prdy", up_op_prdy, 1);
    chk("rst_in_vz", in_vz, 0);
    chk("rst_op_vz", op_vz, 0);
    chk("rst_out_vz", out_vz, 1);
    chk("rst_dn_pvld", dn_pvld, 0);
    chk("rst_in_z", in_z, 0);
    chk("rst_dn_pd", dn_pd, 0);
    chk("rst_idle", idle, 1);
    rstn = 1'b1;
    step();

    // Single word, latency 1, then consume
    up_in_pvld = 1; up_in_pd = 128'h1;
    step();
    up_in_pvld = 0;
    chk("single_vz", in_vz, 1);
    chk("single_z", in_z, 128'h1);
    chk("single_op_vz", op_vz, 0);
    chk("single_idle_lag", idle, 1);
    in_lz = 1;
    step();
    in_lz = 0;
    chk("single_pop_vz", in_vz, 0);
    chk("single_idle_busy", idle, 0);
    step();
    chk("single_idle_back", idle, 1);

    // Backpressure: A, B fill the FIFO, C waits upstream
    up_in_pvld = 1; up_in_pd = WA;
    step();
    up_in_pd = WB;
    step();
    chk("bp_full_prdy", up_in_prdy, 0);
    up_in_pd = WC;
    step();
    chk("bp_hold_prdy", up_in_prdy, 0);
    chk("bp_head_A", in_z, WA);
    in_lz = 1;   // pop A; full at this edge so C still not taken
    step();
    in_lz = 0;
    chk("bp_prdy_back", up_in_prdy, 1);
    chk("bp_head_B", in_z, WB);
    step();      // C accepted
    up_in_pvld = 0;
    chk("bp_after_C_full", up_in_prdy, 0);
    chk("bp_head_B2", in_z, WB);
    in_lz = 1;
    step();
    chk("bp_head_C", in_z, WC);
    step();
    in_lz = 0;
    chk("bp_drained", in_vz, 0);

    // Operand channel: simultaneous push/pop at count=1
    up_op_pvld = 1; up_op_pd = 128'd0;
    step();
    chk("pp_head0", op_z, 128'd0);
    for (int i = 1; i <= 9; i++) begin
      up_op_pd = 128'(i); op_lz = 1;
      step();
      chk("pp_head", op_z, 128'(i));
      chk("pp_prdy", up_op_prdy, 1);
      chk("pp_vz", op_vz, 1);
    end
    up_op_pvld = 0; op_lz = 1;
    step();
    op_lz = 0;
    chk("pp_empty", op_vz, 0);

    // Output path with downstream stalled
    out_lz = 1; out_z = 128'hDEAD;
    step();
    chk("out1_vz", out_vz, 1);
    chk("out1_pvld", dn_pvld, 1);
    chk("out1_pd", dn_pd, 128'hDEAD);
    out_z = 128'hBEEF;
    step();
    chk("out2_full_vz", out_vz, 0);
    out_z = 128'hCAFE;   // offered while full: must be dropped by the bridge
    step();
    out_lz = 0;
    chk("out_stall_vz", out_vz, 0);
    chk("out_stall_pd", dn_pd, 128'hDEAD);
    dn_prdy = 1;
    step();
    chk("out_drain1_pd", dn_pd, 128'hBEEF);
    chk("out_drain1_vz", out_vz, 1);
    step();
    chk("out_drain2_pvld", dn_pvld, 0);
    dn_prdy = 0;
    // capture and pop in one cycle
    out_lz = 1; out_z = 128'h1111;
    step();
    dn_prdy = 1; out_z = 128'h2222;
    step();
    out_lz = 0;
    chk("out_cp_pd", dn_pd, 128'h2222);
    chk("out_cp_pvld", dn_pvld, 1);
    chk("out_cp_vz", out_vz, 1);
    step();
    dn_prdy = 0;
    chk("out_cp_empty", dn_pvld, 0);
    step();

    // Spurious lz on empty FIFOs
    chk("spur_idle_pre", idle, 1);
    in_lz = 1; op_lz = 1;
    step();
    in_lz = 0; op_lz = 0;
    chk("spur_in_vz", in_vz, 0);
    chk("spur_op_vz", op_vz, 0);
    chk("spur_in_prdy", up_in_prdy, 1);
    step();
    chk("spur_idle", idle, 1);
    up_in_pvld = 1; up_in_pd = 128'h77;
    step();
    up_in_pvld = 0;
    chk("spur_next_z", in_z, 128'h77);
    in_lz = 1;
    step();
    in_lz = 0;
    chk("spur_next_empty", in_vz, 0);

`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
    chk("perf_in", perf_in, 32'd5);
    chk("perf_op", perf_op, 32'd10);
    chk("perf_out", perf_out, 32'd4);
    chk("perf_stall", perf_stall, 32'd1);
`endif

    // Reset mid-burst with words buffered
    up_in_pvld = 1; up_op_pvld = 1; up_in_pd = 128'h5; up_op_pd = 128'h6;
    out_lz = 1; out_z = 128'h7;
    step();
    out_lz = 0;
    step();
    up_in_pvld = 0; up_op_pvld = 0;
    chk("mb_in_full", up_in_prdy, 0);
    chk("mb_dn_pvld", dn_pvld, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mb_rst_in_vz", in_vz, 0);
    chk("mb_rst_op_vz", op_vz, 0);
    chk("mb_rst_dn_pvld", dn_pvld, 0);
    chk("mb_rst_out_vz", out_vz, 1);
    chk("mb_rst_in_z", in_z, 0);
    chk("mb_rst_idle", idle, 1);
`ifdef SDP_Y_ALU_BRIDGE_PERF_EN
    chk("mb_perf_in", perf_in, 0);
    chk("mb_perf_op", perf_op, 0);
    chk("mb_perf_out", perf_out, 0);
    chk("mb_perf_stall", perf_stall, 0);
`endif
    step();
    rstn = 1'b1;
    step();
    chk("mb_post_in_prdy", up_in_prdy, 1);
    chk("mb_post_op_prdy", up_op_prdy, 1);
    chk("mb_post_in_vz", in_vz, 0);
    chk("mb_post_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdp_y_alu_chn_bridge.md
Name: sdp_y_alu_chn_bridge

Overview:
- Channel-side partner of the SDP Y ALU core. Drives the core's wait-handshake input channels (chn_alu_in, chn_alu_op) from upstream pvld/prdy streams, and drains the core's output channel (chn_alu_out) into a downstream pvld/prdy stream.
- One independent DEPTH-entry FIFO per channel decouples the core's single-cycle lz pulses from pipeline backpressure.
- Sits between the SDP Y datapath pipe and the ALU core.

Parameters:
- DW, 128, payload width of every channel.
- DEPTH, 2, entries per channel FIFO; must be >= 2 and a power of two.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- up_in_pvld  in  1  upstream ALU-input valid
- up_in_prdy  out  1  upstream ALU-input ready
- up_in_pd  in  DW  upstream ALU-input payload
- up_op_pvld  in  1  upstream operand valid
- up_op_prdy  out  1  upstream operand ready
- up_op_pd  in  DW  upstream operand payload
- chn_alu_in_rsc_z  out  DW  head of the input FIFO, to the core
- chn_alu_in_rsc_vz  out  1  input FIFO non-empty
- chn_alu_in_rsc_lz  in  1  core consume pulse
- chn_alu_op_rsc_z  out  DW  head of the operand FIFO
- chn_alu_op_rsc_vz  out  1  operand FIFO non-empty
- chn_alu_op_rsc_lz  in  1  core consume pulse
- chn_alu_out_rsc_z  in  DW  core result
- chn_alu_out_rsc_vz  out  1  output FIFO not full (space available)
- chn_alu_out_rsc_lz  in  1  core result-valid pulse
- dn_out_pvld  out  1  downstream valid
- dn_out_prdy  in  1  downstream ready
- dn_out_pd  out  DW  downstream payload
- bridge_idle  out  1  all three FIFOs empty

Behaviour:
- Reset:
  - All FIFO counts and pointers go to 0.
  - up_*_prdy=1, chn_*_rsc_vz(in/op)=0, chn_alu_out_rsc_vz=1, dn_out_pvld=0.
  - All z/pd outputs=0; bridge_idle=1.
- Input and operand channels (identical, fully independent):
  - Push when up_x_pvld && up_x_prdy.
  - up_x_prdy = (count != DEPTH), taken from registered count only. It has no combinational path from lz.
  - vz = (count != 0); z = entry at the read pointer.
  - Pop when lz && vz. lz while vz=0 is ignored and does not change state.
  - No bypass: a word pushed into an empty FIFO appears on z/vz the next cycle (latency 1).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, prdy=0 even if lz is asserted that cycle, so no push is possible.
- Output channel:
  - chn_alu_out_rsc_vz = (count != DEPTH).
  - Capture chn_alu_out_rsc_z when lz && vz.
  - dn_out_pvld = (count != 0); dn_out_pd = head entry; pop on dn_out_prdy && dn_out_pvld.
  - Simultaneous capture and pop: count unchanged.
  - When full, vz=0 and the core holds its result.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.
- bridge_idle is registered: it goes high the cycle after all three counts reach 0.
- Reset mid-transfer discards all buffered words; no partial state survives.
- Word order is strictly preserved per channel. The block applies no cross-channel pairing; pairing of in/op words is the core's responsibility.

Optional Feature:
- Macro: SDP_Y_ALU_BRIDGE_PERF_EN.
- Defined:
  - Adds outputs perf_in_cnt, perf_op_cnt, perf_out_cnt (32 bits each) and perf_stall_cnt (32 bits).
  - perf_in/op/out_cnt count core-side transfers per channel.
  - perf_stall_cnt counts cycles with chn_alu_out_rsc_lz=1 and vz=0.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package sdp_y_alu_pkg holds:
  - Constants SDP_Y_ALU_DW=128 and SDP_Y_ALU_BRIDGE_DEPTH=2.
  - Typedef of the channel payload word.
  - Counter width derivation.
- One sub-module, sdp_y_alu_chn_fifo: a DEPTH x DW sync FIFO with push/pop, full/empty and count. It is instantiated three times.

Test Plan:
- Single word: up_in_pd=128'h1 with pvld for 1 cycle -> chn_alu_in_rsc_vz=1 and z=128'h1 on the next cycle; lz pulse -> vz=0 the cycle after.
- Backpressure: push 3 words (A, B, C) with no lz -> prdy=0 after 2 pushes and C is held upstream; one lz -> prdy=1 and C is accepted; order A, B, C is preserved on z.
- Simultaneous push and pop at count=1 for 10 cycles -> count stays 1, no loss or duplication, sequence 0..9 matches.
- Output path: core lz with 128'hDEAD while dn_out_prdy=0 for 2 results -> chn_alu_out_rsc_vz=0; dn_out_prdy=1 -> results drain in order and vz returns to 1.
- Spurious lz with an empty FIFO -> no pointer movement and bridge_idle stays 1.
- Assert nvdla_core_rstn low mid-burst with 2 words buffered -> all vz/pvld go to 0 asynchronously and prdy=1 after release. With PERF_EN defined, all counters read 0.
